// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC; advances, holds on hazard/freeze, or waits for branch resolution.
// Latency: PC/state/freeze/timeout registered (1 edge); fetch_enable and npc combinational.
// Backpressure: wait_for_next_in/freeze_in hold fetch; WAIT_TGT emits bubbles until resolution or timeout.
//
// Ports: clock/reset (sync, active-high); hazard inputs wait_for_next_in, freeze_in, jump_in;
// resolution inputs target_valid_in, taken_in, target_in; outputs pc_out, npc_out,
// fetch_enable_out, freeze_out, timeout_out, state_out.
// Optional: define FETCH_PERF_CNT_EN to add stall_count_out / bubble_count_out (saturating).
module fetch_sequencer #(
    parameter int                      BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0]    PC_INCREMENT = 1,
    parameter int                      PHASES       = 5,
    parameter logic [BUS_WIDTH-1:0]    RESET_PC     = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wait_for_next_in,
    input  logic                 freeze_in,
    input  logic                 jump_in,
    input  logic                 target_valid_in,
    input  logic                 taken_in,
    input  logic [BUS_WIDTH-1:0] target_in,
    output logic [BUS_WIDTH-1:0] pc_out,
    output logic [BUS_WIDTH-1:0] npc_out,
    output logic                 fetch_enable_out,
    output logic                 freeze_out,
    output logic                 timeout_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]          stall_count_out,
    output logic [15:0]          bubble_count_out,
`endif
    output logic [1:0]           state_out
);

    localparam int CNT_W = (PHASES > 1) ? $clog2(PHASES) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD     = 2'd1,
        WAIT_TGT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [BUS_WIDTH-1:0] pc_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 timeout_nxt;
    logic                 hold;

    assign hold             = wait_for_next_in | freeze_in;
    assign fetch_enable_out = (state == RUN) & ~hold & ~jump_in;
    assign npc_out          = pc_out + PC_INCREMENT;
    assign state_out        = state;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_out;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            RUN: begin
                if (jump_in) begin
                    state_nxt = WAIT_TGT;
                    cnt_nxt   = '0;
                end else if (hold) begin
                    state_nxt = HOLD;
                end else begin
                    pc_nxt = pc_out + PC_INCREMENT;
                end
            end
            HOLD: begin
                if (jump_in) begin
                    state_nxt = WAIT_TGT;
                    cnt_nxt   = '0;
                end else if (!hold) begin
                    state_nxt = RUN;
                end
            end
            WAIT_TGT: begin
                // jump_in and hold are deliberately ignored while a transfer is pending.
                cnt_nxt = cnt + CNT_W'(1);
                if (target_valid_in) begin
                    // Not-taken needs no PC change: the PC was held at the fall-through address.
                    if (taken_in) begin
                        pc_nxt = target_in;
                    end
                    state_nxt = RUN;
                end else if (cnt == CNT_W'(PHASES - 2)) begin
                    // This is the (PHASES-1)th waiting cycle: give up and resume.
                    timeout_nxt = 1'b1;
                    state_nxt   = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            pc_out      <= RESET_PC;
            cnt         <= '0;
            freeze_out  <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc_out      <= pc_nxt;
            cnt         <= cnt_nxt;
            freeze_out  <= (state_nxt == WAIT_TGT);
            timeout_out <= timeout_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_out  <= '0;
            bubble_count_out <= '0;
        end else begin
            if (state == HOLD && stall_count_out != 16'hFFFF) begin
                stall_count_out <= stall_count_out + 16'd1;
            end
            if (state == WAIT_TGT && bubble_count_out != 16'hFFFF) begin
                bubble_count_out <= bubble_count_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed stimulus, behavioural model, per-cycle compare.
module tb_fetch_sequencer;

    localparam int PHASES = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        wait_for_next_in, freeze_in, jump_in;
    logic        target_valid_in, taken_in;
    logic [31:0] target_in;
    logic [31:0] pc_out, npc_out;
    logic        fetch_enable_out, freeze_out, timeout_out;
    logic [1:0]  state_out;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_count_out, bubble_count_out;
`endif

    fetch_sequencer #(
        .BUS_WIDTH(32), .PC_INCREMENT(32'd1), .PHASES(PHASES), .RESET_PC(32'd0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wait_for_next_in(wait_for_next_in),
        .freeze_in(freeze_in),
        .jump_in(jump_in),
        .target_valid_in(target_valid_in),
        .taken_in(taken_in),
        .target_in(target_in),
        .pc_out(pc_out),
        .npc_out(npc_out),
        .fetch_enable_out(fetch_enable_out),
        .freeze_out(freeze_out),
        .timeout_out(timeout_out),
`ifdef FETCH_PERF_CNT_EN
        .stall_count_out(stall_count_out),
        .bubble_count_out(bubble_count_out),
`endif
        .state_out(state_out)
    );

    always #5 clock = ~clock;

    // Behavioural model: mode names as integers, waited = WAIT_TGT cycles spent so far.
    bit          m_valid = 1'b0;
    logic [31:0] m_pc;
    int          m_mode;
    int          m_waited;
    bit          m_freeze, m_timeout;
    int          m_stall, m_bubble;
    bit          m_hold;

    always @(posedge clock) begin
        m_hold    = wait_for_next_in | freeze_in;
        m_timeout = 1'b0;
        if (reset) begin
            m_valid  = 1'b1;
            m_pc     = 32'd0;
            m_mode   = 0;
            m_waited = 0;
            m_stall  = 0;
            m_bubble = 0;
        end else if (m_valid) begin
            if (m_mode == 1 && m_stall < 65535)  m_stall++;
            if (m_mode == 2 && m_bubble < 65535) m_bubble++;
            case (m_mode)
                0: begin
                    if (jump_in) begin m_mode = 2; m_waited = 0; end
                    else if (m_hold) m_mode = 1;
                    else m_pc = m_pc + 32'd1;
                end
                1: begin
                    if (jump_in) begin m_mode = 2; m_waited = 0; end
                    else if (!m_hold) m_mode = 0;
                end
                default: begin
                    m_waited++;
                    if (target_valid_in) begin
                        if (taken_in) m_pc = target_in;
                        m_mode = 0;
                    end else if (m_waited == PHASES - 1) begin
                        m_timeout = 1'b1;
                        m_mode    = 0;
                    end
                end
            endcase
        end
        m_freeze = (m_mode == 2);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1; wait_for_next_in = 1'b0; freeze_in = 1'b0; jump_in = 1'b0;
        target_valid_in = 1'b0; taken_in = 1'b0; target_in = 32'd0;

        // Per-cycle compare against the model, away from the active edge.
        fork
            forever begin
                @(negedge clock);
                if (m_valid) begin
                    chk("pc_out", pc_out, m_pc);
                    chk("npc_out", npc_out, m_pc + 32'd1);
                    chk("fetch_enable_out", {31'd0, fetch_enable_out},
                        {31'd0, (m_mode == 0) && !(wait_for_next_in | freeze_in) && !jump_in});
                    chk("freeze_out", {31'd0, freeze_out}, {31'd0, m_freeze});
                    chk("timeout_out", {31'd0, timeout_out}, {31'd0, m_timeout});
                    chk("state_out", {30'd0, state_out}, m_mode);
`ifdef FETCH_PERF_CNT_EN
                    chk("stall_count_out", {16'd0, stall_count_out}, m_stall);
                    chk("bubble_count_out", {16'd0, bubble_count_out}, m_bubble);
`endif
                end
            end
        join_none

        cyc(); reset = 1'b0;
        chk("lit_reset_pc", pc_out, 32'd0);
        chk("lit_reset_npc", npc_out, 32'd1);
        chk("lit_reset_state", {30'd0, state_out}, 32'd0);
        chk("lit_reset_freeze", {31'd0, freeze_out}, 32'd0);
        chk("lit_reset_fetch_en", {31'd0, fetch_enable_out}, 32'd1);

        // Sequential advance
        cyc(); cyc(); cyc();
        chk("lit_seq_pc3", pc_out, 32'd3);
        chk("model_seq_pc3", m_pc, 32'd3);

        // Hazard hold for two cycles
        wait_for_next_in = 1'b1; #1;
        chk("lit_hold_fetch_en", {31'd0, fetch_enable_out}, 32'd0);
        cyc(); chk("lit_hold_state", {30'd0, state_out}, 32'd1);
        cyc(); wait_for_next_in = 1'b0;
        cyc(); chk("lit_hold_release_state", {30'd0, state_out}, 32'd0);
        chk("lit_hold_release_pc", pc_out, 32'd3);
        cyc(); chk("lit_hold_next_pc", pc_out, 32'd4);
        cyc();

        // Taken branch resolved on the second WAIT_TGT cycle
        jump_in = 1'b1; #1;
        chk("lit_jump_fetch_en", {31'd0, fetch_enable_out}, 32'd0);
        cyc(); jump_in = 1'b0;
        chk("lit_wait_freeze", {31'd0, freeze_out}, 32'd1);
        chk("lit_wait_pc", pc_out, 32'd5);
        cyc(); target_valid_in = 1'b1; taken_in = 1'b1; target_in = 32'h40;
        cyc(); target_valid_in = 1'b0; taken_in = 1'b0; target_in = 32'd0;
        chk("lit_taken_pc", pc_out, 32'h40);
        chk("lit_taken_freeze", {31'd0, freeze_out}, 32'd0);
        chk("model_taken_pc", m_pc, 32'h40);
`ifdef FETCH_PERF_CNT_EN
        chk("lit_stall_count", {16'd0, stall_count_out}, 32'd2);
        chk("lit_bubble_count", {16'd0, bubble_count_out}, 32'd2);
`endif
        cyc(); chk("lit_taken_next_pc", pc_out, 32'h41);

        // Not-taken resolved on the first WAIT_TGT cycle
        jump_in = 1'b1;
        cyc(); jump_in = 1'b0; target_valid_in = 1'b1; taken_in = 1'b0; target_in = 32'h99;
        cyc(); target_valid_in = 1'b0;
        chk("lit_nt_pc", pc_out, 32'h41);
        chk("lit_nt_state", {30'd0, state_out}, 32'd0);
        cyc(); chk("lit_nt_next_pc", pc_out, 32'h42);

        // Timeout: no resolution for PHASES-1 cycles
        jump_in = 1'b1;
        cyc(); jump_in = 1'b0;
        cyc(); cyc(); cyc();
        chk("lit_to_w4_state", {30'd0, state_out}, 32'd2);
        chk("lit_to_w4_timeout", {31'd0, timeout_out}, 32'd0);
        cyc();
        chk("lit_to_pulse", {31'd0, timeout_out}, 32'd1);
        chk("model_to_pulse", {31'd0, m_timeout}, 32'd1);
        chk("lit_to_pc", pc_out, 32'h42);
        chk("lit_to_state", {30'd0, state_out}, 32'd0);
        cyc(); chk("lit_to_pulse_end", {31'd0, timeout_out}, 32'd0);

        // Resolution on the timeout cycle wins
        jump_in = 1'b1;
        cyc(); jump_in = 1'b0;
        cyc(); cyc(); cyc();
        target_valid_in = 1'b1; taken_in = 1'b1; target_in = 32'h100;
        cyc(); target_valid_in = 1'b0; taken_in = 1'b0;
        chk("lit_race_timeout", {31'd0, timeout_out}, 32'd0);
        chk("lit_race_pc", pc_out, 32'h100);

        // Resolution outside WAIT_TGT is ignored
        target_valid_in = 1'b1; taken_in = 1'b1; target_in = 32'h77;
        cyc(); target_valid_in = 1'b0; taken_in = 1'b0;
        chk("lit_stray_tv_pc", pc_out, 32'h101);

        // PC wrap
        jump_in = 1'b1;
        cyc(); jump_in = 1'b0; target_valid_in = 1'b1; taken_in = 1'b1; target_in = 32'hFFFF_FFFF;
        cyc(); target_valid_in = 1'b0; taken_in = 1'b0;
        chk("lit_wrap_pc", pc_out, 32'hFFFF_FFFF);
        chk("lit_wrap_npc", npc_out, 32'd0);
        cyc(); chk("lit_wrap_next_pc", pc_out, 32'd0);
        cyc();

        // Jump and hold together in RUN, then reset inside WAIT_TGT
        jump_in = 1'b1; wait_for_next_in = 1'b1;
        cyc();
        chk("lit_jh_state", {30'd0, state_out}, 32'd2);
        chk("lit_jh_pc", pc_out, 32'd1);
        cyc(); reset = 1'b1; jump_in = 1'b0;
        cyc(); reset = 1'b0; wait_for_next_in = 1'b0;
        chk("lit_rst_wait_pc", pc_out, 32'd0);
        chk("lit_rst_wait_freeze", {31'd0, freeze_out}, 32'd0);
        chk("lit_rst_wait_state", {30'd0, state_out}, 32'd0);

        // Jump and freeze together in HOLD
        freeze_in = 1'b1;
        cyc(); chk("lit_frz_hold_state", {30'd0, state_out}, 32'd1);
        jump_in = 1'b1;
        cyc(); jump_in = 1'b0; freeze_in = 1'b0;
        chk("lit_hj_state", {30'd0, state_out}, 32'd2);
        target_valid_in = 1'b1; taken_in = 1'b0;
        cyc(); target_valid_in = 1'b0;
        chk("lit_hj_resume_pc", pc_out, 32'd0);
        cyc(); cyc();
        @(negedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control sequencer for the instruction fetch stage. Owns the program counter and decides, each cycle, whether fetch advances sequentially, holds for a hazard or downstream freeze, or waits on and redirects to a resolved branch target. It drives the instruction-memory read address and strobe, and inserts freeze bubbles downstream while a control transfer is unresolved. It sits between the instruction checker/decode (jump and hazard requests) and execute (target resolution).

## Interface
- bus_width, 32, width of PC and target
- pc_increment, 1, sequential PC step
- phases, 5, maximum cycles to wait for target resolution before timeout; must be ≥ 2
- reset_pc, 0, PC value after reset

Ports (clock and reset first):
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wait_for_next_in  in  1  decode hazard; hold fetch
- freeze_in  in  1  downstream freeze; hold fetch
- jump_in  in  1  control-transfer instruction detected; one-cycle pulse
- target_valid_in  in  1  execute has resolved the pending transfer
- taken_in  in  1  resolved transfer is taken; qualified by target_valid_in
- target_in  in  bus_width  resolved target address
- pc_out  out  bus_width  instruction-memory read address (registered)
- npc_out  out  bus_width  pc_out + pc_increment (combinational from pc_out)
- fetch_enable_out  out  1  memory read strobe (combinational)
- freeze_out  out  1  bubble request to downstream (registered)
- timeout_out  out  1  one-cycle pulse: resolution not received in time (registered)
- state_out  out  2  current state: 0 RUN, 1 HOLD, 2 WAIT_TGT

## Operation
- hold = wait_for_next_in | freeze_in
- fetch_enable_out = (state == RUN) & !hold & !jump_in
- Event priority per edge: reset > target resolution (WAIT_TGT only) > jump_in > hold > advance
- RUN:
  - jump_in → WAIT_TGT; PC holds; bubble counter cleared.
  - Else hold → HOLD; PC holds.
  - Else pc ← pc + pc_increment.
- HOLD:
  - jump_in → WAIT_TGT.
  - Else if hold is low → RUN; PC unchanged. The first fetch from the held PC occurs in the RUN cycle.
  - Else stay in HOLD.
- WAIT_TGT:
  - freeze_out = 1 and fetch_enable_out = 0 throughout; jump_in and hold are ignored.
  - target_valid_in & taken_in → pc ← target_in, go to RUN.
  - target_valid_in & !taken_in → PC unchanged (already the fall-through address), go to RUN.
  - Bubble counter increments each cycle. If it reaches phases − 1 without target_valid_in, assert timeout_out for one cycle, go to RUN, PC unchanged.
  - target_valid_in on the same cycle as the timeout: resolution wins and no timeout is raised.
- target_valid_in outside WAIT_TGT is ignored.
- Arithmetic:
  - pc + pc_increment wraps modulo 2^bus_width; there is no overflow flag.
  - Counter width is $clog2(phases).

## Timing
- Reset values: pc_out = reset_pc, state RUN, freeze_out = 0, timeout_out = 0, counter 0. Then npc_out = reset_pc + pc_increment, and fetch_enable_out = 1 unless hold or jump_in is high.
- Reset asserted mid-operation (any state) returns to the reset values on the next edge and discards any pending target.
- PC update latency: one edge after the deciding inputs are sampled.
- freeze_out rises on the edge that enters WAIT_TGT and falls on the edge that leaves it.
- Minimum WAIT_TGT occupancy is 1 cycle; maximum is phases − 1 cycles.
- Simultaneous jump_in and hold in RUN or HOLD: jump wins.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two outputs.
  - stall_count_out [15:0] counts cycles spent in HOLD.
  - bubble_count_out [15:0] counts cycles spent in WAIT_TGT.
  - Both saturate at 0xFFFF and clear on reset.
- FETCH_PERF_CNT_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then 4 idle cycles → pc_out 0,1,2,3,4; fetch_enable_out = 1 each cycle; freeze_out = 0.
- At pc = 3, wait_for_next_in high for 2 cycles → state HOLD, pc_out stays 3 for 3 cycles, then 4; fetch_enable_out = 0 while held.
- jump_in at pc = 5; after 2 cycles, target_valid_in = 1, taken_in = 1, target_in = 0x40 → freeze_out high for 2 cycles, then pc_out = 0x40, 0x41, freeze_out = 0.
- jump_in at pc = 5; after 1 cycle, target_valid_in = 1, taken_in = 0 → pc_out stays 5, then 6.
- jump_in at pc = 5 with no resolution, phases = 5 → timeout_out pulses once after 4 WAIT_TGT cycles; resume at pc = 5. Repeat with target_valid_in on the timeout cycle → no pulse, redirect taken.
- Boundary cases:
  - pc = 0xFFFFFFFF advances to 0.
  - Reset asserted in WAIT_TGT → pc_out = reset_pc and freeze_out = 0 next cycle.
  - Jump and hold together → WAIT_TGT.
  - With FETCH_PERF_CNT_EN: counters read 2 (HOLD) and 2 (WAIT_TGT) after the above scenarios.
